voice_allocator: RTL and testbench

Polyphonic voice scheduler between the MIDI parser and the per-voice sample-generator/envelope chains. It takes note events over a valid/ready handshake and assigns each note-on to one of VOICES voice slots. When all slots are busy it steals the oldest voice. It drives a gate, note index and velocity per voice for the downstream generators and envelopes.

---
 rtl/voice_allocator.sv | 179 +++++++++++++++++
 tb/tb_voice_allocator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Polyphonic voice scheduler; assigns note events to voice slots,
//            stealing the oldest gated voice when every slot is busy.
// Revision : 1.0
// ============================================================================
module voice_allocator #(
    parameter int VOICES = 4
) (
    input  logic                  inCLK,
    input  logic                  inReset,
    input  logic                  inEventValid,
    input  logic [1:0]            inEventType,
    input  logic [6:0]            inNote,
    input  logic [6:0]            inVelocity,
    output logic                  outEventReady,
    output logic [VOICES-1:0]     outGate,
    output logic [7*VOICES-1:0]   outNote,
    output logic [7*VOICES-1:0]   outVelocity,
    output logic                  outSteal,
    output logic [2:0]            outStealVoice
);
    localparam int         c_IDX_W  = $clog2(VOICES);
    localparam logic [1:0] c_EV_OFF = 2'd0;
    localparam logic [1:0] c_EV_ON  = 2'd1;
    localparam logic [1:0] c_EV_ALL = 2'd2;
    localparam logic [1:0] c_EV_RSV = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, APPLY = 2'd2} state_t;
    state_t r_state, w_nextState;

    logic [1:0]         r_evType;
    logic [6:0]         r_evNote, r_evVel;
    logic [c_IDX_W-1:0] r_scanIdx;
    logic               r_matchFound, r_freeFound, r_oldFound;
    logic [c_IDX_W-1:0] r_matchIdx, r_freeIdx, r_oldIdx;
    logic [7:0]         r_oldAge;
    logic [VOICES-1:0]  r_gate;
    logic [6:0]         r_note [VOICES];
    logic [6:0]         r_vel  [VOICES];
    logic [7:0]         r_age  [VOICES];
    logic               r_steal;
    logic [2:0]         r_stealVoice;
    logic               w_accept, w_scanLast, w_isSteal;
    logic [c_IDX_W-1:0] w_target;

    assign outEventReady = (r_state == IDLE);
    assign w_accept      = inEventValid && outEventReady;
    assign w_scanLast    = (r_scanIdx == c_IDX_W'(VOICES - 1));

    always_ff @(posedge inCLK or posedge inReset) begin
        if (inReset) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (inEventType == c_EV_ALL)      w_nextState = APPLY;
                    else if (inEventType != c_EV_RSV) w_nextState = SCAN;
                end
            end
            SCAN:    if (w_scanLast) w_nextState = APPLY;
            APPLY:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Priority: retrigger an already-sounding note, then a free slot, then steal.
    always_comb begin
        w_target  = r_matchIdx;
        w_isSteal = 1'b0;
        if (!r_matchFound) begin
            if (r_freeFound) begin
                w_target = r_freeIdx;
            end else begin
                w_target  = r_oldIdx;
                w_isSteal = 1'b1;
            end
        end
    end

    always_ff @(posedge inCLK or posedge inReset) begin
        if (inReset) begin
            r_evType     <= c_EV_OFF;
            r_evNote     <= '0;
            r_evVel      <= '0;
            r_scanIdx    <= '0;
            r_matchFound <= 1'b0;
            r_freeFound  <= 1'b0;
            r_oldFound   <= 1'b0;
            r_matchIdx   <= '0;
            r_freeIdx    <= '0;
            r_oldIdx     <= '0;
            r_oldAge     <= '0;
        end else if (w_accept) begin
            // A note-on with zero velocity is a note-off by MIDI convention.
            r_evType     <= (inEventType == c_EV_ON && inVelocity == 7'd0) ? c_EV_OFF : inEventType;
            r_evNote     <= inNote;
            r_evVel      <= inVelocity;
            r_scanIdx    <= '0;
            r_matchFound <= 1'b0;
            r_freeFound  <= 1'b0;
            r_oldFound   <= 1'b0;
            r_matchIdx   <= '0;
            r_freeIdx    <= '0;
            r_oldIdx     <= '0;
            r_oldAge     <= '0;
        end else if (r_state == SCAN) begin
            r_scanIdx <= r_scanIdx + c_IDX_W'(1);
            if (!r_matchFound && r_gate[r_scanIdx] && r_note[r_scanIdx] == r_evNote) begin
                r_matchFound <= 1'b1;
                r_matchIdx   <= r_scanIdx;
            end
            if (!r_freeFound && !r_gate[r_scanIdx]) begin
                r_freeFound <= 1'b1;
                r_freeIdx   <= r_scanIdx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (r_gate[r_scanIdx] && (!r_oldFound || r_age[r_scanIdx] > r_oldAge)) begin
                r_oldFound <= 1'b1;
                r_oldIdx   <= r_scanIdx;
                r_oldAge   <= r_age[r_scanIdx];
            end
        end
    end

    always_ff @(posedge inCLK or posedge inReset) begin
        if (inReset) begin
            r_gate       <= '0;
            r_steal      <= 1'b0;
            r_stealVoice <= '0;
            for (int v = 0; v < VOICES; v++) begin
                r_note[v] <= '0;
                r_vel[v]  <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_steal <= 1'b0;
            if (r_state == APPLY) begin
                case (r_evType)
                    c_EV_ON: begin
                        for (int v = 0; v < VOICES; v++) begin
                            if (c_IDX_W'(v) == w_target) begin
                                r_gate[v] <= 1'b1;
                                r_note[v] <= r_evNote;
                                r_vel[v]  <= r_evVel;
                                r_age[v]  <= 8'd0;
                            end else if (r_gate[v] && r_age[v] != 8'hFF) begin
                                r_age[v] <= r_age[v] + 8'd1;
                            end
                        end
                        if (w_isSteal) begin
                            r_steal      <= 1'b1;
                            r_stealVoice <= 3'(w_target);
                        end
                    end
                    c_EV_OFF: if (r_matchFound) r_gate[r_matchIdx] <= 1'b0;
                    c_EV_ALL: r_gate <= '0;
                    default:  ;
                endcase
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_pack
        assign outNote[7*v +: 7]     = r_note[v];
        assign outVelocity[7*v +: 7] = r_vel[v];
    end

    assign outGate       = r_gate;
    assign outSteal      = r_steal;
    assign outStealVoice = r_stealVoice;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Scoreboard bench for voice_allocator with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;
    localparam int VOICES = 4;

    logic                inCLK = 1'b0;
    logic                inReset = 1'b1;
    logic                inEventValid = 1'b0;
    logic [1:0]          inEventType = '0;
    logic [6:0]          inNote = '0;
    logic [6:0]          inVelocity = '0;
    logic                outEventReady;
    logic [VOICES-1:0]   outGate;
    logic [7*VOICES-1:0] outNote;
    logic [7*VOICES-1:0] outVelocity;
    logic                outSteal;
    logic [2:0]          outStealVoice;

    voice_allocator #(.VOICES(VOICES)) dut (
        .inCLK        (inCLK),
        .inReset      (inReset),
        .inEventValid (inEventValid),
        .inEventType  (inEventType),
        .inNote       (inNote),
        .inVelocity   (inVelocity),
        .outEventReady(outEventReady),
        .outGate      (outGate),
        .outNote      (outNote),
        .outVelocity  (outVelocity),
        .outSteal     (outSteal),
        .outStealVoice(outStealVoice)
    );

    always #5 inCLK = ~inCLK;

    typedef struct packed {
        logic [7:0]          lowCycles;
        logic [VOICES-1:0]   gate;
        logic [7*VOICES-1:0] notes;
        logic [7*VOICES-1:0] vels;
        logic                steal;
        logic [2:0]          stealVoice;
    } exp_t;

    exp_t sbQ[$];
    int   nAssert = 0;
    int   nFail   = 0;

    logic [VOICES-1:0] mGate;
    logic [6:0]        mNote [VOICES];
    logic [6:0]        mVel  [VOICES];
    logic [7:0]        mAge  [VOICES];
    logic [2:0]        mStealV;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mGate   = '0;
        mStealV = '0;
        for (int v = 0; v < VOICES; v++) begin
            mNote[v] = '0;
            mVel[v]  = '0;
            mAge[v]  = '0;
        end
    endtask

    // Reference behaviour: match, else lowest free, else oldest gated voice.
    task automatic modelEvent(input logic [1:0] t, input logic [6:0] n, input logic [6:0] vel, output exp_t e);
        logic [1:0] typ;
        int match, free, old, tgt;
        typ = (t == 2'd1 && vel == 7'd0) ? 2'd0 : t;
        e.steal = 1'b0;
        match = -1; free = -1; old = -1;
        for (int v = 0; v < VOICES; v++) begin
            if (match < 0 && mGate[v] && mNote[v] == n) match = v;
            if (free < 0 && !mGate[v]) free = v;
            if (mGate[v] && (old < 0 || mAge[v] > mAge[old])) old = v;
        end
        case (typ)
            2'd1: begin
                tgt = (match >= 0) ? match : (free >= 0) ? free : old;
                for (int v = 0; v < VOICES; v++) begin
                    if (v == tgt) begin
                        mGate[v] = 1'b1; mNote[v] = n; mVel[v] = vel; mAge[v] = 8'd0;
                    end else if (mGate[v] && mAge[v] < 8'd255) begin
                        mAge[v] = mAge[v] + 8'd1;
                    end
                end
                if (match < 0 && free < 0) begin
                    e.steal = 1'b1;
                    mStealV = 3'(tgt);
                end
            end
            2'd0: if (match >= 0) mGate[match] = 1'b0;
            2'd2: mGate = '0;
            default: ;
        endcase
        e.lowCycles  = (typ == 2'd3) ? 8'd0 : (typ == 2'd2) ? 8'd1 : 8'(VOICES + 1);
        e.gate       = mGate;
        e.stealVoice = mStealV;
        for (int v = 0; v < VOICES; v++) begin
            e.notes[7*v +: 7] = mNote[v];
            e.vels[7*v +: 7]  = mVel[v];
        end
    endtask

    // Drives one event, keeps junk on the bus while busy, then scores the result.
    task automatic sendEvent(input logic [1:0] t, input logic [6:0] n, input logic [6:0] vel,
                             output logic obsSteal);
        exp_t e, got;
        int   lowCycles;
        @(negedge inCLK);
        inEventValid = 1'b1; inEventType = t; inNote = n; inVelocity = vel;
        modelEvent(t, n, vel, e);
        sbQ.push_back(e);
        @(negedge inCLK);
        lowCycles = 0;
        while (!outEventReady && lowCycles < 20) begin
            inEventValid = 1'b1; inEventType = 2'd1; inNote = 7'd127; inVelocity = 7'd1;
            lowCycles++;
            @(negedge inCLK);
        end
        inEventValid = 1'b0;
        got = sbQ.pop_front();
        checkVal("readyLowCycles", 64'(lowCycles), 64'(got.lowCycles));
        checkVal("gate", 64'(outGate), 64'(got.gate));
        checkVal("notes", 64'(outNote), 64'(got.notes));
        checkVal("vels", 64'(outVelocity), 64'(got.vels));
        checkVal("steal", 64'(outSteal), 64'(got.steal));
        checkVal("stealVoice", 64'(outStealVoice), 64'(got.stealVoice));
        obsSteal = outSteal;
        @(negedge inCLK);
        checkVal("stealPulseEnd", 64'(outSteal), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "Gate"}, 64'(outGate), 64'd0);
        checkVal({tag, "Notes"}, 64'(outNote), 64'd0);
        checkVal({tag, "Vels"}, 64'(outVelocity), 64'd0);
        checkVal({tag, "Steal"}, 64'(outSteal), 64'd0);
        checkVal({tag, "StealV"}, 64'(outStealVoice), 64'd0);
        checkVal({tag, "Ready"}, 64'(outEventReady), 64'd1);
    endtask

    initial begin
        logic s;
        modelReset();
        repeat (3) @(negedge inCLK);
        checkResetState("rst");
        inReset = 1'b0;
        @(negedge inCLK);
        checkResetState("postRst");

        // Single note-on lands on voice 0.
        sendEvent(2'd1, 7'd60, 7'd100, s);
        checkVal("tp1Gate", 64'(outGate), 64'b0001);
        checkVal("tp1Note0", 64'(outNote[6:0]), 64'd60);
        checkVal("tp1Vel0", 64'(outVelocity[6:0]), 64'd100);
        checkVal("tp1Steal", 64'(s), 64'd0);

        // Fill all voices then steal the oldest.
        sendEvent(2'd1, 7'd62, 7'd90, s);
        sendEvent(2'd1, 7'd64, 7'd80, s);
        sendEvent(2'd1, 7'd67, 7'd70, s);
        sendEvent(2'd1, 7'd72, 7'd60, s);
        checkVal("tp2Steal", 64'(s), 64'd1);
        checkVal("tp2StealV", 64'(outStealVoice), 64'd0);
        checkVal("tp2Gate", 64'(outGate), 64'b1111);
        checkVal("tp2Note0", 64'(outNote[6:0]), 64'd72);
        checkVal("tp2Note3", 64'(outNote[27:21]), 64'd67);

        sendEvent(2'd2, 7'd0, 7'd0, s);
        checkVal("tp5AllOff", 64'(outGate), 64'b0000);

        // Note-off frees a slot that the next note-on reuses.
        sendEvent(2'd1, 7'd60, 7'd10, s);
        sendEvent(2'd1, 7'd62, 7'd20, s);
        sendEvent(2'd1, 7'd64, 7'd30, s);
        sendEvent(2'd0, 7'd62, 7'd0, s);
        checkVal("tp3Gate", 64'(outGate), 64'b0101);
        checkVal("tp3Note1Kept", 64'(outNote[13:7]), 64'd62);
        sendEvent(2'd1, 7'd65, 7'd40, s);
        checkVal("tp3Note1", 64'(outNote[13:7]), 64'd65);
        checkVal("tp3Gate2", 64'(outGate), 64'b0111);

        // Retrigger and velocity-zero release.
        sendEvent(2'd2, 7'd0, 7'd0, s);
        sendEvent(2'd1, 7'd60, 7'd50, s);
        sendEvent(2'd1, 7'd60, 7'd30, s);
        checkVal("tp4Gate", 64'(outGate), 64'b0001);
        checkVal("tp4Vel0", 64'(outVelocity[6:0]), 64'd30);
        sendEvent(2'd1, 7'd60, 7'd0, s);
        checkVal("tp4Off", 64'(outGate), 64'b0000);

        // Reserved type and unmatched note-off change nothing.
        sendEvent(2'd1, 7'd70, 7'd55, s);
        sendEvent(2'd3, 7'd33, 7'd44, s);
        checkVal("rsvGate", 64'(outGate), 64'b0001);
        sendEvent(2'd0, 7'd50, 7'd0, s);
        checkVal("noMatchGate", 64'(outGate), 64'b0001);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 6)      sendEvent(2'd1, 7'(60 + $urandom_range(0, 5)), 7'($urandom_range(0, 127)), s);
            else if (k < 8) sendEvent(2'd0, 7'(60 + $urandom_range(0, 5)), 7'd0, s);
            else if (k < 9) sendEvent(2'd2, 7'd0, 7'd0, s);
            else            sendEvent(2'd3, 7'd1, 7'd1, s);
        end

        // Reset in the middle of a scan discards the event.
        sendEvent(2'd1, 7'd61, 7'd61, s);
        @(negedge inCLK);
        inEventValid = 1'b1; inEventType = 2'd1; inNote = 7'd99; inVelocity = 7'd99;
        @(negedge inCLK);
        inEventValid = 1'b0;
        @(negedge inCLK);
        inReset = 1'b1;
        @(negedge inCLK);
        checkResetState("midScanRst");
        inReset = 1'b0;
        modelReset();
        repeat (VOICES + 3) @(negedge inCLK);
        checkResetState("abortedEvent");

        sendEvent(2'd1, 7'd48, 7'd77, s);
        checkVal("afterRstGate", 64'(outGate), 64'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
